local_mult_arbiter: RTL and testbench
=====================================

# local_mult_arbiter

Round-robin scheduler that shares one registered 64x64 unsigned multiplier (`local_mult_64_64_128`) among `NREQ` requesters. It accepts one operand pair per cycle through valid/ready handshakes and registers the operands into the multiplier. A tag pipeline travels alongside the multiplier latency, and each product is returned on a single shared response port with the requester ID. The block sits between vector-lane/scalar multiply issue logic and the multiplier instance, and drives the multiplier's `clken` for backpressure.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: requester ID width, `clog2(NREQ)`.
- `LPM_WIDTHA`, 64: operand A width.
- `LPM_WIDTHB`, 64: operand B width.
- `LPM_WIDTHP`, 128: product width.
- `LAT`, 1: multiplier register latency in `clken`-qualified cycles, 1..4.

Ports:
- `clock` in 1: sole clock.
- `aclr` in 1: reset, asynchronous and active-high. Tie it to the multiplier's `aclr` as well.
- `req_valid` in NREQ: per-requester request.
- `req_ready` out NREQ: per-requester accept; one-hot or zero.
- `req_dataa` in NREQ*LPM_WIDTHA: packed operand A; requester i occupies slice [i*LPM_WIDTHA +: LPM_WIDTHA].
- `req_datab` in NREQ*LPM_WIDTHB: packed operand B, same packing.
- `resp_valid` out 1: product available.
- `resp_id` out IDW: index of the requester that owns the product.
- `resp_result` out LPM_WIDTHP: product; passes through from `mult_result`.
- `resp_ready` in 1: consumer accepts the response.
- `mult_dataa` out LPM_WIDTHA: registered operand A to the multiplier.
- `mult_datab` out LPM_WIDTHB: registered operand B to the multiplier.
- `mult_clken` out 1: advance enable to the multiplier.
- `mult_result` in LPM_WIDTHP: multiplier output.
- `inflight` out clog2(LAT+2): number of operations accepted but not yet retired.

## Operation
- **Advance:** `adv = !(resp_valid && !resp_ready)`. `mult_clken = adv`. The issue stage and the tag stages load only when `adv=1`.
- **Arbitration:** the search starts at `(ptr+1) mod NREQ` and scans upward with wrap-around. The first asserted `req_valid` is granted. `req_ready[g]=1` only when `adv=1`; otherwise all `req_ready` bits are 0.
  - `ptr` updates to g only on an accepted grant.
  - `req_ready` depends on `req_valid` combinationally. A requester must not wait on `req_ready` before asserting `req_valid`.
- **Issue stage:** on acceptance, `mult_dataa`/`mult_datab` load requester g's slices and `tag0 = {1, g}`.
  - When `adv=1` and nothing is granted, `tag0.valid` becomes 0 and the operand registers hold their values, to avoid toggling.
- **Tag pipeline:** `tag[k] <= tag[k-1]` for k=1..LAT, gated by `adv`.
  - `resp_valid = tag[LAT].valid` and `resp_id = tag[LAT].id`.
  - `resp_result = mult_result`, with no extra register.
- **Bubbles:** bubbles advance freely. An invalid `tag[LAT]` never blocks `adv`.
- **Inflight counter:** `inflight` increments on accept and decrements on a retire (`resp_valid && resp_ready`). Both in the same cycle leave it unchanged. Its maximum is LAT+1.
- **Ordering:** responses are returned strictly in acceptance order. There is no reordering.

## Timing
- **Reset (async `aclr`=1):**
  - All tag valids 0, `ptr=NREQ-1` (requester 0 has first priority), `inflight=0`.
  - `mult_dataa=0`, `mult_datab=0`.
  - `resp_valid=0`, `resp_id=0`, `req_ready=0`, `mult_clken=1`.
- **Reset mid-operation:** in-flight operations are discarded, with no response emitted. The multiplier is cleared by the shared `aclr`.
- **Latency:** an accept at edge T gives `resp_valid=1` after edge T+1+LAT, assuming no stalls. For LAT=1 that is 2 cycles.
- **Throughput:** one accept per cycle while `resp_ready=1`.
- **Stall:** while `resp_valid=1` and `resp_ready=0`, all state freezes. `resp_result`, `resp_id` and `resp_valid` hold stable and no request is accepted.
- **Stall release:** when `resp_ready` rises, the retire and a new accept happen on the same edge.
- **Overflow:** not possible. At most LAT+1 operations can be in flight, because acceptance requires `adv`.

## Test plan
- **Single request:** after reset, req 2 presents A=3, B=5 for one cycle → `req_ready[2]=1` that cycle; two cycles later `resp_valid=1`, `resp_id=2`, `resp_result=15`.
- **Round-robin fairness:** all 4 requesters hold valid continuously with `resp_ready=1` → grants are 0,1,2,3,0,1…; one response per cycle; IDs follow the same order.
- **Full-width arithmetic:** A=B=0xFFFF_FFFF_FFFF_FFFF → `resp_result=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001`.
- **Backpressure:** hold `resp_ready=0` for 5 cycles while all requesters are valid → `req_ready=0`, `mult_clken=0`, and the response is held stable; `inflight=2` (LAT=1). On release the responses drain in order with no loss or duplication.
- **Reset mid-flight:** assert `aclr` one cycle after an accept → `resp_valid` stays 0, `inflight=0`, and the next grant goes to req 0.
- **Bubbles:** requests arrive at cycles 0, 3 and 4 → responses at 2, 5 and 6; `inflight` returns to 0.

Source files
------------

// File: rtl/local_mult_arbiter.sv
// Round-robin front end sharing one registered multiplier among NREQ requesters, with an ID tag pipeline.
// Latency: accept at edge T -> resp_valid after edge T+1+LAT (no stalls); one accept per cycle.
// Backpressure: a held response (resp_valid && !resp_ready) freezes issue, tags and multiplier via clken.
module local_mult_arbiter #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int LPM_WIDTHA = 64,
  parameter int LPM_WIDTHB = 64,
  parameter int LPM_WIDTHP = 128,
  parameter int LAT        = 1
) (
  input  logic                         clock,
  input  logic                         aclr,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*LPM_WIDTHA-1:0]   req_dataa,
  input  logic [NREQ*LPM_WIDTHB-1:0]   req_datab,
  output logic                         resp_valid,
  output logic [IDW-1:0]               resp_id,
  output logic [LPM_WIDTHP-1:0]        resp_result,
  input  logic                         resp_ready,
  output logic [LPM_WIDTHA-1:0]        mult_dataa,
  output logic [LPM_WIDTHB-1:0]        mult_datab,
  output logic                         mult_clken,
  input  logic [LPM_WIDTHP-1:0]        mult_result,
  output logic [$clog2(LAT+2)-1:0]     inflight
);

  localparam int CNTW = $clog2(LAT+2);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  tag_t           tag_q [LAT+1];
  logic [IDW-1:0] ptr;
  logic           adv;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic           accept;
  logic           retire;

  // The whole pipeline only holds while a valid response is refused; bubbles never stall it.
  assign resp_valid  = tag_q[LAT].vld;
  assign resp_id     = tag_q[LAT].id;
  assign resp_result = mult_result;
  assign adv         = !(resp_valid && !resp_ready);
  assign mult_clken  = adv;
  assign accept      = adv && grant_vld && !aclr;
  assign retire      = resp_valid && resp_ready;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  // One-hot ready only for the winner, and only when the pipeline can move.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Issue stage: operands load on accept only, so idle cycles do not toggle the multiplier inputs.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      mult_dataa <= '0;
      mult_datab <= '0;
      ptr        <= IDW'(NREQ-1);
    end else if (accept) begin
      mult_dataa <= req_dataa[int'(grant_id)*LPM_WIDTHA +: LPM_WIDTHA];
      mult_datab <= req_datab[int'(grant_id)*LPM_WIDTHB +: LPM_WIDTHB];
      ptr        <= grant_id;
    end
  end

  // Tag pipeline shadows the multiplier register stages so the ID pops out with its product.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
    end else if (adv) begin
      tag_q[0] <= {accept, grant_id};
      for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Occupancy: accepted but not yet handed to the consumer.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      inflight <= '0;
    end else if (accept && !retire) begin
      inflight <= inflight + CNTW'(1);
    end else if (!accept && retire) begin
      inflight <= inflight - CNTW'(1);
    end
  end

endmodule

// File: tb/tb_local_mult_arbiter.sv
// Bench for local_mult_arbiter: directed vector table, reset corner, randomized run vs a queue model.
// Latency: checks sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: resp_ready is driven by the bench to create stalls.
module tb_local_mult_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int WA   = 64;
  localparam int WB   = 64;
  localparam int WP   = 128;
  localparam int LAT  = 1;

  logic                      clock = 1'b0;
  logic                      aclr;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*WA-1:0]        req_dataa;
  logic [NREQ*WB-1:0]        req_datab;
  logic                      resp_valid;
  logic [IDW-1:0]            resp_id;
  logic [WP-1:0]             resp_result;
  logic                      resp_ready;
  logic [WA-1:0]             mult_dataa;
  logic [WB-1:0]             mult_datab;
  logic                      mult_clken;
  logic [WP-1:0]             mult_result;
  logic [$clog2(LAT+2)-1:0]  inflight;

  local_mult_arbiter #(.NREQ(NREQ), .IDW(IDW), .LPM_WIDTHA(WA), .LPM_WIDTHB(WB),
                       .LPM_WIDTHP(WP), .LAT(LAT)) dut (
    .clock(clock), .aclr(aclr), .req_valid(req_valid), .req_ready(req_ready),
    .req_dataa(req_dataa), .req_datab(req_datab), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_result(resp_result), .resp_ready(resp_ready),
    .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_clken(mult_clken),
    .mult_result(mult_result), .inflight(inflight)
  );

  always #5 clock = ~clock;

  // Behavioural registered multiplier with clken and shared async clear.
  logic [WP-1:0] mp [LAT];
  always @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k < LAT; k++) mp[k] <= '0;
    end else if (mult_clken) begin
      mp[0] <= WP'(mult_dataa) * WP'(mult_datab);
      for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
  end
  assign mult_result = mp[LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [WP-1:0] act, input logic [WP-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] vld;
    logic [WA-1:0]   a;
    logic [WB-1:0]   b;
    logic            rr;
    logic [NREQ-1:0] e_rdy;
    logic            e_rv;
    logic [IDW-1:0]  e_id;
    logic [WP-1:0]   e_res;
    logic            e_clken;
    int              e_inf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [NREQ-1:0] vld, input logic [WA-1:0] a, input logic [WB-1:0] b,
                     input logic rr, input logic [NREQ-1:0] e_rdy, input logic e_rv,
                     input logic [IDW-1:0] e_id, input logic [WP-1:0] e_res,
                     input logic e_clken, input int e_inf);
    vec_t v;
    v.vld = vld; v.a = a; v.b = b; v.rr = rr; v.e_rdy = e_rdy; v.e_rv = e_rv;
    v.e_id = e_id; v.e_res = e_res; v.e_clken = e_clken; v.e_inf = e_inf;
    tbl.push_back(v);
  endtask

  task automatic set_ops(input logic [WA-1:0] a, input logic [WB-1:0] b);
    for (int i = 0; i < NREQ; i++) begin
      req_dataa[i*WA +: WA] = a;
      req_datab[i*WB +: WB] = b;
    end
  endtask

  // Reference model: ordered queue of accepted operations, each aging once per advancing edge.
  typedef struct {
    int            id;
    logic [WP-1:0] prod;
    int            age;
  } op_t;

  op_t mq[$];
  int  m_ptr;

  task automatic model_cycle();
    logic            e_rv;
    logic            e_adv;
    logic [NREQ-1:0] e_rdy;
    int              g;
    op_t             t;
    e_rv  = (mq.size() > 0) && (mq[0].age == LAT);
    e_adv = !(e_rv && !resp_ready);
    g     = -1;
    for (int off = 1; off <= NREQ; off++)
      if (g < 0 && req_valid[(m_ptr + off) % NREQ]) g = (m_ptr + off) % NREQ;
    e_rdy = '0;
    if (e_adv && g >= 0) e_rdy[g] = 1'b1;
    chk("rnd_req_ready", WP'(req_ready), WP'(e_rdy));
    chk("rnd_resp_valid", WP'(resp_valid), WP'(e_rv));
    chk("rnd_clken", WP'(mult_clken), WP'(e_adv));
    chk("rnd_inflight", WP'(inflight), WP'(mq.size()));
    if (e_rv) begin
      chk("rnd_resp_id", WP'(resp_id), WP'(mq[0].id));
      chk("rnd_resp_result", resp_result, mq[0].prod);
    end
    if (e_adv) begin
      if (e_rv && resp_ready) void'(mq.pop_front());
      for (int k = 0; k < mq.size(); k++) begin
        t = mq[k];
        t.age = t.age + 1;
        mq[k] = t;
      end
      if (g >= 0) begin
        t.id   = g;
        t.prod = WP'(req_dataa[g*WA +: WA]) * WP'(req_datab[g*WB +: WB]);
        t.age  = 0;
        mq.push_back(t);
        m_ptr = g;
      end
    end
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    aclr = 1'b0;
  endtask

  localparam logic [WA-1:0] ONES = {WA{1'b1}};
  localparam logic [WP-1:0] FULL = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;

  initial begin
    aclr = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    req_dataa = '0;
    req_datab = '0;

    // Reset state
    @(negedge clock);
    chk("rst_resp_valid", WP'(resp_valid), '0);
    chk("rst_resp_id", WP'(resp_id), '0);
    chk("rst_req_ready", WP'(req_ready), '0);
    chk("rst_clken", WP'(mult_clken), WP'(1));
    chk("rst_inflight", WP'(inflight), '0);
    chk("rst_mult_dataa", WP'(mult_dataa), '0);
    chk("rst_mult_datab", WP'(mult_datab), '0);
    @(negedge clock);
    aclr = 1'b0;

    // vld, a, b, rr | e_rdy, e_rv, e_id, e_res, e_clken, e_inf
    add(4'b0100, 3, 5, 1,  4'b0100, 0, 0, 0,  1, 0);   // single request from req 2
    add(4'b0000, 0, 0, 1,  4'b0000, 0, 0, 0,  1, 1);
    add(4'b0000, 0, 0, 1,  4'b0000, 1, 2, 15, 1, 1);
    add(4'b0000, 0, 0, 1,  4'b0000, 0, 0, 0,  1, 0);
    add(4'b0001, ONES, ONES, 1, 4'b0001, 0, 0, 0, 1, 0); // full width, then round robin
    add(4'b1111, 2, 7, 1,  4'b0010, 0, 0, 0,  1, 1);
    add(4'b1111, 4, 4, 1,  4'b0100, 1, 0, FULL, 1, 2);
    add(4'b1111, 1, 9, 1,  4'b1000, 1, 1, 14, 1, 2);
    add(4'b0000, 0, 0, 1,  4'b0000, 1, 2, 16, 1, 2);
    add(4'b0000, 0, 0, 1,  4'b0000, 1, 3, 9,  1, 1);
    add(4'b0000, 0, 0, 1,  4'b0000, 0, 0, 0,  1, 0);
    add(4'b1111, 5, 6, 0,  4'b0001, 0, 0, 0,  1, 0);   // backpressure
    add(4'b1111, 6, 6, 0,  4'b0010, 0, 0, 0,  1, 1);
    for (int s = 0; s < 5; s++)
      add(4'b1111, 7, 7, 0, 4'b0000, 1, 0, 30, 0, 2);
    add(4'b1111, 7, 7, 1,  4'b0100, 1, 0, 30, 1, 2);   // release: retire + accept
    add(4'b0000, 0, 0, 1,  4'b0000, 1, 1, 36, 1, 2);
    add(4'b0000, 0, 0, 1,  4'b0000, 1, 2, 49, 1, 1);
    add(4'b0000, 0, 0, 1,  4'b0000, 0, 0, 0,  1, 0);
    add(4'b0001, 2, 3, 1,  4'b0001, 0, 0, 0,  1, 0);   // bubbles: cycles 0, 3, 4
    add(4'b0000, 0, 0, 1,  4'b0000, 0, 0, 0,  1, 1);
    add(4'b0000, 0, 0, 1,  4'b0000, 1, 0, 6,  1, 1);
    add(4'b0010, 3, 3, 1,  4'b0010, 0, 0, 0,  1, 0);
    add(4'b0100, 4, 4, 1,  4'b0100, 0, 0, 0,  1, 1);
    add(4'b0000, 0, 0, 1,  4'b0000, 1, 1, 9,  1, 2);
    add(4'b0000, 0, 0, 1,  4'b0000, 1, 2, 16, 1, 1);
    add(4'b0000, 0, 0, 1,  4'b0000, 0, 0, 0,  1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clock); #1;
      req_valid  = tbl[i].vld;
      resp_ready = tbl[i].rr;
      set_ops(tbl[i].a, tbl[i].b);
      @(negedge clock);
      chk($sformatf("vec%0d_req_ready", i), WP'(req_ready), WP'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_resp_valid", i), WP'(resp_valid), WP'(tbl[i].e_rv));
      chk($sformatf("vec%0d_clken", i), WP'(mult_clken), WP'(tbl[i].e_clken));
      chk($sformatf("vec%0d_inflight", i), WP'(inflight), WP'(tbl[i].e_inf));
      if (tbl[i].e_rv) begin
        chk($sformatf("vec%0d_resp_id", i), WP'(resp_id), WP'(tbl[i].e_id));
        chk($sformatf("vec%0d_resp_result", i), resp_result, tbl[i].e_res);
      end
    end

    // Reset one cycle after an accept: the operation vanishes, priority returns to req 0
    @(posedge clock); #1;
    req_valid = 4'b0010;
    set_ops(3, 3);
    @(negedge clock);
    chk("mid_accept_rdy", WP'(req_ready), WP'(4'b0010));
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    chk("mid_inflight_pre", WP'(inflight), WP'(1));
    aclr = 1'b1;
    #1;
    chk("mid_inflight_rst", WP'(inflight), '0);
    chk("mid_resp_valid_rst", WP'(resp_valid), '0);
    chk("mid_req_ready_rst", WP'(req_ready), '0);
    @(posedge clock); #1;
    chk("mid_resp_valid_post", WP'(resp_valid), '0);
    @(negedge clock);
    aclr = 1'b0;
    @(posedge clock); #1;
    req_valid = 4'b1111;
    set_ops(8, 8);
    @(negedge clock);
    chk("mid_next_grant", WP'(req_ready), WP'(4'b0001));
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    chk("mid_no_stale_resp", WP'(resp_valid), '0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("mid_new_resp_id", WP'(resp_id), '0);
    chk("mid_new_resp_result", resp_result, WP'(64));

    // Randomized run against the queue model
    do_reset();
    mq.delete();
    m_ptr = NREQ - 1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock); #1;
      if (c < 3900) begin
        req_valid  = NREQ'($urandom);
        resp_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < NREQ; i++) begin
          req_dataa[i*WA +: WA] = ($urandom_range(0, 15) == 0) ? ONES : {$urandom, $urandom};
          req_datab[i*WB +: WB] = ($urandom_range(0, 15) == 0) ? ONES : {$urandom, $urandom};
        end
      end else begin
        req_valid  = '0;
        resp_ready = 1'b1;
      end
      @(negedge clock);
      model_cycle();
    end
    chk("rnd_drained_inflight", WP'(inflight), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
